// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-to-1 channel multiplexer:
// mode encodings and the round-robin pointer wrap increment.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set in_valid bit at or above
// rr_ptr, searching upward modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  in_valid,
    input  logic [SW-1:0] rr_ptr,
    output logic [SW-1:0] grant,
    output logic          grant_valid
);

    int w_dist;
    int w_best;

    // Rank each channel by its forward distance from the pointer; nearest valid wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_best      = N;
        w_dist      = 0;
        for (int k = 0; k < N; k++) begin
            w_dist = (k >= int'(rr_ptr)) ? (k - int'(rr_ptr)) : (k + N - int'(rr_ptr));
            if (in_valid[k] && (w_dist < w_best)) begin
                w_best      = w_dist;
                grant       = SW'(k);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 channel mux with manual or round-robin selection and a
// one-entry valid/ready output register. Optional out_parity via MUX_PARITY_EN.
module mux_nto1_seq
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 1,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel_in,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
`ifdef MUX_PARITY_EN
    ,
    output logic           out_parity
`endif
);

    logic [SW-1:0] r_rr_ptr;
    logic [SW-1:0] r_out_chan;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;

    logic [SW-1:0] w_rr_grant;
    logic          w_rr_valid;
    logic          w_man_valid;
    logic [SW-1:0] w_grant;
    logic          w_grant_valid;
    logic          w_slot_free;
    logic          w_capture;
    logic [W-1:0]  w_grant_data;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .in_valid    (in_valid),
        .rr_ptr      (r_rr_ptr),
        .grant       (w_rr_grant),
        .grant_valid (w_rr_valid)
    );

    // Out-of-range select values match no channel, so they never grant.
    always_comb begin
        w_man_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if ((sel_in == SW'(k)) && in_valid[k]) begin
                w_man_valid = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode == MODE_AUTO) begin
            w_grant       = w_rr_grant;
            w_grant_valid = w_rr_valid;
        end else begin
            w_grant       = sel_in;
            w_grant_valid = w_man_valid;
        end
    end

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_capture   = w_slot_free && w_grant_valid;

    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SW'(k)) begin
                w_grant_data = in_data[k*W +: W];
            end
        end
    end

    // rst_n gating keeps every ready low while reset is held, even though the slot reads free.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            in_ready[k] = rst_n && w_capture && (w_grant == SW'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_chan  <= w_grant;
                if (mode == MODE_AUTO) begin
                    r_rr_ptr <= SW'(rr_next(32'(w_grant), N));
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

`ifdef MUX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_capture) begin
            r_parity <= ^w_grant_data;
        end
    end

    assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Bench for mux_nto1_seq: an N=4 and an N=3 instance (W=8) share stimulus and
// are each tracked by a behavioural model; MUX_PARITY_EN adds parity checks.
module tb_mux_nto1_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        mode      = 1'b0;
    logic [1:0]  sel       = 2'd0;
    logic [31:0] din       = 32'd0;
    logic [3:0]  vin       = 4'd0;
    logic        out_ready = 1'b0;

    logic [3:0]  rdy4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ov4;
    logic [2:0]  rdy3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ov3;
    logic        op4;
    logic        op3;

    int checks   = 0;
    int failures = 0;

    bit         m_valid[2];
    logic [7:0] m_data[2];
    int         m_chan[2];
    int         m_ptr[2];

    always #5 clk = ~clk;

    mux_nto1_seq #(.N(4), .W(8)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel_in    (sel),
        .in_data   (din),
        .in_valid  (vin),
        .in_ready  (rdy4),
        .out_data  (od4),
        .out_chan  (oc4),
        .out_valid (ov4),
        .out_ready (out_ready)
`ifdef MUX_PARITY_EN
        ,
        .out_parity(op4)
`endif
    );

    mux_nto1_seq #(.N(3), .W(8)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel_in    (sel),
        .in_data   (din[23:0]),
        .in_valid  (vin[2:0]),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_chan  (oc3),
        .out_valid (ov3),
        .out_ready (out_ready)
`ifdef MUX_PARITY_EN
        ,
        .out_parity(op3)
`endif
    );

`ifndef MUX_PARITY_EN
    assign op4 = 1'b0;
    assign op3 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare one instance against its model, then advance the model through the coming edge.
    task automatic step_model(input int id, input int n, input logic [3:0] rdy,
                              input logic [7:0] od, input logic [1:0] oc,
                              input logic ov, input logic op);
        bit   sf;
        bit   gv;
        int   g;
        int   c;
        logic [3:0] exp_rdy;
        chk($sformatf("i%0d out_valid", id), 32'(ov), 32'(m_valid[id]));
        chk($sformatf("i%0d out_data", id), 32'(od), 32'(m_data[id]));
        chk($sformatf("i%0d out_chan", id), 32'(oc), 32'(m_chan[id]));
`ifdef MUX_PARITY_EN
        chk($sformatf("i%0d out_parity", id), 32'(op), 32'(^m_data[id]));
`else
        if (op !== 1'b0) chk($sformatf("i%0d parity tie", id), 32'(op), 32'd0);
`endif
        sf = !m_valid[id] || out_ready;
        gv = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < n && vin[sel]) begin
                gv = 1'b1;
                g  = int'(sel);
            end
        end else begin
            for (int off = 0; off < n; off++) begin
                c = (m_ptr[id] + off) % n;
                if (!gv && vin[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
        exp_rdy = (gv && sf) ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("i%0d in_ready", id), 32'(rdy), 32'(exp_rdy));
        if (gv && sf) begin
            m_valid[id] = 1'b1;
            m_data[id]  = din[g*8 +: 8];
            m_chan[id]  = g;
            if (mode) m_ptr[id] = (g + 1) % n;
        end else if (m_valid[id] && out_ready) begin
            m_valid[id] = 1'b0;
        end
    endtask

    task automatic reset_model(input int id, input logic [3:0] rdy, input logic [7:0] od,
                               input logic [1:0] oc, input logic ov);
        chk($sformatf("i%0d rst out_valid", id), 32'(ov), 32'd0);
        chk($sformatf("i%0d rst out_data", id), 32'(od), 32'd0);
        chk($sformatf("i%0d rst out_chan", id), 32'(oc), 32'd0);
        chk($sformatf("i%0d rst in_ready", id), 32'(rdy), 32'd0);
        m_valid[id] = 1'b0;
        m_data[id]  = 8'd0;
        m_chan[id]  = 0;
        m_ptr[id]   = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            reset_model(0, rdy4, od4, oc4, ov4);
            reset_model(1, {1'b0, rdy3}, od3, oc3, ov3);
        end else begin
            step_model(0, 4, rdy4, od4, oc4, ov4, op4);
            step_model(1, 3, {1'b0, rdy3}, od3, oc3, ov3, op3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    int seq_a[5] = '{0, 1, 2, 3, 0};
    int seq_a3[5] = '{0, 1, 2, 0, 1};
    int seq_b[4] = '{0, 3, 0, 3};

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 8'd0;
            m_chan[i]  = 0;
            m_ptr[i]   = 0;
        end
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Manual select
        mode = 1'b0; sel = 2'd2; din = 32'd0; din[23:16] = 8'hA5; vin = 4'b0100; out_ready = 1'b1;
        #1 chk("man in_ready", 32'(rdy4), 32'h4);
        tick();
        chk("man out_data", 32'(od4), 32'hA5);
        chk("man out_chan", 32'(oc4), 32'd2);
        chk("man out_valid", 32'(ov4), 32'd1);
        vin = 4'b1011;
        #1 chk("man no-valid in_ready", 32'(rdy4), 32'd0);
        tick();
        chk("man drain out_valid", 32'(ov4), 32'd0);
        chk("man hold out_data", 32'(od4), 32'hA5);

        // Auto fairness, all channels valid
        do_reset();
        mode = 1'b1; vin = 4'hF; out_ready = 1'b1; din = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr all n4 step%0d", i), 32'(oc4), 32'(seq_a[i]));
            chk($sformatf("rr all n3 step%0d", i), 32'(oc3), 32'(seq_a3[i]));
        end

        // Auto fairness, sparse valid
        do_reset();
        vin = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr sparse step%0d", i), 32'(oc4), 32'(seq_b[i]));
            chk($sformatf("rr sparse valid%0d", i), 32'(ov4), 32'd1);
        end

        // Backpressure then release with no bubble
        do_reset();
        vin = 4'hF; out_ready = 1'b0; din = 32'hDDCCBBAA;
        tick();
        chk("bp first data", 32'(od4), 32'hAA);
        for (int i = 0; i < 3; i++) begin
            din = $urandom;
            #1 chk($sformatf("bp in_ready%0d", i), 32'(rdy4), 32'd0);
            tick();
            chk($sformatf("bp hold data%0d", i), 32'(od4), 32'hAA);
            chk($sformatf("bp hold chan%0d", i), 32'(oc4), 32'd0);
        end
        din = 32'hDDCCBBAA; out_ready = 1'b1;
        #1 chk("bp release in_ready", 32'(rdy4), 32'h2);
        tick();
        chk("bp release chan", 32'(oc4), 32'd1);
        chk("bp release data", 32'(od4), 32'hBB);
        chk("bp release valid", 32'(ov4), 32'd1);

        // N=3 boundary: out-of-range select, then pointer wrap after ch2
        do_reset();
        mode = 1'b0; sel = 2'd3; vin = 4'b0111; out_ready = 1'b1;
        #1 chk("n3 sel3 in_ready", 32'(rdy3), 32'd0);
        tick();
        chk("n3 sel3 no capture", 32'(ov3), 32'd0);
        mode = 1'b1; vin = 4'b0100;
        #1 chk("n3 auto ch2 ready", 32'(rdy3), 32'h4);
        tick();
        chk("n3 auto ch2 chan", 32'(oc3), 32'd2);
        vin = 4'b0111;
        tick();
        chk("n3 wrap chan", 32'(oc3), 32'd0);

`ifdef MUX_PARITY_EN
        do_reset();
        mode = 1'b0; sel = 2'd0; vin = 4'b0001; out_ready = 1'b1; din = 32'h07;
        tick();
        chk("parity 07", 32'(op4), 32'd1);
        din = 32'h03;
        tick();
        chk("parity 03", 32'(op4), 32'd0);
`endif

        // Asynchronous reset while words are flowing
        mode = 1'b1; vin = 4'hF; out_ready = 1'b1; din = 32'h12345678;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(ov4), 32'd0);
        chk("async rst out_data", 32'(od4), 32'd0);
        chk("async rst in_ready", 32'(rdy4), 32'd0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
            sel       = 2'($urandom);
            din       = $urandom;
            vin       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
